cmd_parser: RTL

CMD_PARSER -- requirements
Module: cmd_parser

---
 rtl/cmd_parser.sv | 115 +++++++++++
 1 files changed

// File: rtl/cmd_parser.sv
// cmd_parser: bit-serial command decoder that classifies the opcode, tracks packet length and captures Query fields.
// Ports:
//   reset           async active-high clear of all state
//   bitinclk        one rising edge per received bit
//   bitin           received bit, sampled on posedge bitinclk
//   packettype      one-hot command: [0]QueryRep [1]ACK [2]Query [3]QueryAdjust [4]Select [5]NAK [6]ReqRN [7]Read [8]Write
//   cmd_complete    opcode resolved (known or unknown)
//   packet_complete last bit of a fixed- or EBV-length packet received
//   cmd_unknown     opcode resolved but unsupported
//   dr, m, trext, session  Query fields
module cmd_parser (
  input  logic       reset,
  input  logic       bitinclk,
  input  logic       bitin,
  output logic [8:0] packettype,
  output logic       cmd_complete,
  output logic       packet_complete,
  output logic       cmd_unknown,
  output logic       dr,
  output logic [1:0] m,
  output logic       trext,
  output logic [1:0] session
);
  logic [6:0] r_bitcount;
  logic [6:0] r_op;
  logic [1:0] r_k;
  logic       r_ebv_done;
  logic [7:0] w_opc;
  logic [8:0] w_dec;
  logic       w_unk;
  logic [8:0] w_type;
  logic [6:0] w_last;
  logic       w_has_len;
  logic       w_done;
  logic       w_ebv;
  // Opcode bits received so far, including the bit on the current edge.
  assign w_opc = {r_op, bitin};
  // Resolve the opcode as soon as its prefix is conclusive; the decode is
  // combinational so a packet whose final bit is its last opcode bit (NAK)
  // can complete on the same edge.
  always_comb begin
    w_dec = '0;
    w_unk = 1'b0;
    if (!cmd_complete) begin
      if (r_bitcount == 7'd1 && !w_opc[1])
        w_dec = w_opc[0] ? 9'h002 : 9'h001;
      else if (r_bitcount == 7'd2 && w_opc[2:0] == 3'b111)
        w_unk = 1'b1;
      else if (r_bitcount == 7'd3 && w_opc[3:2] == 2'b10) begin
        w_unk = w_opc[1:0] == 2'b11;
        w_dec = w_unk ? 9'h000 : 9'h004 << w_opc[1:0];
      end
      else if (r_bitcount == 7'd3 && w_opc[3:0] == 4'b1101)
        w_unk = 1'b1;
      else if (r_bitcount == 7'd7) begin
        w_unk = w_opc[7:2] != 6'b110000;
        w_dec = w_unk ? 9'h000 : 9'h020 << w_opc[1:0];
      end
    end
  end
  assign w_type = cmd_complete ? packettype : w_dec;
  // Index of the final bit; Read/Write grow by one byte per EBV extension.
  assign w_last = w_type[0] ? 7'd3  :
                  w_type[1] ? 7'd17 :
                  w_type[2] ? 7'd21 :
                  w_type[3] ? 7'd8  :
                  w_type[5] ? 7'd7  :
                  w_type[6] ? 7'd39 :
                  w_type[7] ? 7'd57 + {2'b00, r_k, 3'b000} :
                              7'd65 + {2'b00, r_k, 3'b000};
  assign w_has_len = |{w_type[8:5], w_type[3:0]};
  assign w_done = w_has_len && r_bitcount == w_last;
  // EBV extension flags sit at indices 10, 18, 26, ... until the first 0.
  assign w_ebv = r_bitcount >= 7'd10 && r_bitcount[2:0] == 3'd2 && !r_ebv_done && r_k != 2'd3;
  always_ff @(posedge bitinclk or posedge reset) begin
    if (reset) begin
      r_bitcount      <= '0;
      r_op            <= '0;
      r_k             <= '0;
      r_ebv_done      <= 1'b0;
      packettype      <= '0;
      cmd_complete    <= 1'b0;
      cmd_unknown     <= 1'b0;
      packet_complete <= 1'b0;
      dr              <= 1'b0;
      m               <= '0;
      trext           <= 1'b0;
      session         <= '0;
    end else if (!packet_complete) begin
      r_bitcount <= (r_bitcount == 7'd127) ? r_bitcount : r_bitcount + 7'd1;
      r_op       <= w_opc[6:0];
      if (w_dec != 9'h000) begin
        packettype   <= w_dec;
        cmd_complete <= 1'b1;
      end
      if (w_unk) begin
        cmd_unknown  <= 1'b1;
        cmd_complete <= 1'b1;
      end
      if (w_ebv) begin
        r_k        <= bitin ? r_k + 2'd1 : r_k;
        r_ebv_done <= !bitin;
      end
      if (packettype[2]) begin
        dr         <= (r_bitcount == 7'd4)  ? bitin : dr;
        m[1]       <= (r_bitcount == 7'd5)  ? bitin : m[1];
        m[0]       <= (r_bitcount == 7'd6)  ? bitin : m[0];
        trext      <= (r_bitcount == 7'd7)  ? bitin : trext;
        session[1] <= (r_bitcount == 7'd10) ? bitin : session[1];
        session[0] <= (r_bitcount == 7'd11) ? bitin : session[0];
      end
      packet_complete <= w_done;
    end
  end
endmodule
